// File: rtl/ram_pkg.sv
// Shared types for the dual-port RAM with clear sequencer.
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR,
    READY
  } ram_state_t;

endpackage

// File: rtl/ram_dp_clr_if.sv
// User-side bus of ram_dp_clr: write port, read port, clear request and status.
interface ram_dp_clr_if #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned ADDR_W = 5
);
  logic              clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;

  modport master (
    output clear, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  clear, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/ram_dp_core.sv
// Inferable simple dual-port array: synchronous write, registered read-first read.
module ram_dp_core #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/ram_dp_clr.sv
// Dual-port RAM with a clear sequencer filling every word with CLEAR_VAL after reset
// or on request. Define RAM_BYPASS_EN for write-first same-address forwarding.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int unsigned        DATA_W    = 3,
  parameter int unsigned        ADDR_W    = 5,
  parameter int unsigned        DEPTH     = 2 ** ADDR_W,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  ram_dp_clr_if.slave  bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              core_we, core_re, rd_acc;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic              wr_in, rd_in;
  logic              rd_valid_q, oor_q;
  logic [DATA_W-1:0] rd_mux;

  assign wr_in = 32'(bus.wr_addr) < DEPTH;
  assign rd_in = 32'(bus.rd_addr) < DEPTH;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    core_we    = 1'b0;
    core_waddr = bus.wr_addr;
    core_wdata = bus.wr_data;
    core_re    = 1'b0;
    rd_acc     = 1'b0;
    unique case (state_q)
      CLEAR: begin
        core_we    = 1'b1;
        core_waddr = clr_cnt_q;
        core_wdata = CLEAR_VAL;
        clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST) begin
          state_d   = READY;
          clr_cnt_d = '0;
        end
      end
      READY: begin
        // clear wins over any user access in the same cycle
        if (bus.clear) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          core_we = bus.wr_en && wr_in;
          rd_acc  = bus.rd_en;
          core_re = bus.rd_en && rd_in;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  ram_dp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (core_we),
    .waddr   (core_waddr),
    .wdata   (core_wdata),
    .re      (core_re),
    .raddr   (bus.rd_addr),
    .rdata   (core_rdata)
  );

  // Output select flags only change on an accepted read, so rd_data holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) oor_q <= !rd_in;
    end
  end

`ifdef RAM_BYPASS_EN
  logic              byp_q;
  logic [DATA_W-1:0] byp_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else if (rd_acc) begin
      byp_q      <= bus.wr_en && wr_in && (bus.wr_addr == bus.rd_addr);
      byp_data_q <= bus.wr_data;
    end
  end

  assign rd_mux = byp_q ? byp_data_q : core_rdata;
`else
  assign rd_mux = core_rdata;
`endif

  assign bus.rd_data  = oor_q ? CLEAR_VAL : rd_mux;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state_q == CLEAR);
endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr: default instance plus a DEPTH=20, CLEAR_VAL=1 instance.
module tb_ram_dp_clr;
  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ram_dp_clr_if #(.DATA_W(3), .ADDR_W(5)) ba ();
  ram_dp_clr_if #(.DATA_W(3), .ADDR_W(5)) bb ();

  ram_dp_clr u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ba.slave)
  );

  ram_dp_clr #(
    .DATA_W    (3),
    .ADDR_W    (5),
    .DEPTH     (20),
    .CLEAR_VAL (3'd1)
  ) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bb.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [2:0] d);
    ba.wr_en   = 1'b1;
    ba.wr_addr = a;
    ba.wr_data = d;
    cyc();
    ba.wr_en   = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [4:0] a, input logic [2:0] exp);
    ba.rd_en   = 1'b1;
    ba.rd_addr = a;
    cyc();
    ba.rd_en   = 1'b0;
    check_eq({tag, "_valid"}, 32'(ba.rd_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(ba.rd_data), 32'(exp));
  endtask

  task automatic count_busy_a(output int cnt, output int seen_valid);
    cnt = 0;
    seen_valid = 0;
    while (ba.busy && cnt < 100) begin
      cnt++;
      if (ba.rd_valid) seen_valid++;
      cyc();
    end
  endtask

  initial begin
    int ca, cb, sv;
    logic [2:0] exp_byp;

    {ba.clear, ba.wr_en, ba.wr_addr, ba.wr_data, ba.rd_en, ba.rd_addr} = '0;
    {bb.clear, bb.wr_en, bb.wr_addr, bb.wr_data, bb.rd_en, bb.rd_addr} = '0;
    reset_n = 1'b0;
    repeat (2) cyc();
    check_eq("rst_busy", 32'(ba.busy), 32'd1);
    check_eq("rst_valid", 32'(ba.rd_valid), 32'd0);
    check_eq("rst_data", 32'(ba.rd_data), 32'd0);
    check_eq("rst_busy_b", 32'(bb.busy), 32'd1);

    // busy length after release, both depths
    reset_n = 1'b1;
    ca = 0;
    cb = 0;
    for (int i = 0; i < 40; i++) begin
      if (ba.busy) ca++;
      if (bb.busy) cb++;
      cyc();
    end
    check_eq("busy_len_a", 32'(ca), 32'd32);
    check_eq("busy_len_b", 32'(cb), 32'd20);

    for (int i = 0; i < 32; i++) rd_a("clr_rd", 5'(i), 3'd0);
    cyc();
    check_eq("valid_fall", 32'(ba.rd_valid), 32'd0);

    wr_a(5'd0, 3'd3);
    rd_a("wr0", 5'd0, 3'd3);
    cyc();
    check_eq("hold_data", 32'(ba.rd_data), 32'd3);
    check_eq("hold_valid", 32'(ba.rd_valid), 32'd0);

    // same-cycle read/write to one address
    wr_a(5'd4, 3'd2);
`ifdef RAM_BYPASS_EN
    exp_byp = 3'd5;
`else
    exp_byp = 3'd2;
`endif
    ba.wr_en   = 1'b1;
    ba.wr_addr = 5'd4;
    ba.wr_data = 3'd5;
    rd_a("rw_same", 5'd4, exp_byp);
    ba.wr_en = 1'b0;
    rd_a("rw_after", 5'd4, 3'd5);

    // clear together with a write: write dropped, full re-clear
    wr_a(5'd2, 3'd1);
    ba.clear   = 1'b1;
    ba.wr_en   = 1'b1;
    ba.wr_addr = 5'd2;
    ba.wr_data = 3'd6;
    cyc();
    ba.clear = 1'b0;
    ba.wr_en = 1'b0;
    count_busy_a(ca, sv);
    check_eq("clr_busy_len", 32'(ca), 32'd32);
    rd_a("clr_rd2", 5'd2, 3'd0);
    rd_a("clr_rd4", 5'd4, 3'd0);

    // reset pulse mid-clear at clr_cnt=10, reads during busy ignored
    ba.clear = 1'b1;
    cyc();
    ba.clear = 1'b0;
    repeat (10) cyc();
    check_eq("mid_busy", 32'(ba.busy), 32'd1);
    reset_n = 1'b0;
    #2;
    check_eq("pulse_busy", 32'(ba.busy), 32'd1);
    reset_n = 1'b1;
    ba.rd_en   = 1'b1;
    ba.rd_addr = 5'd7;
    count_busy_a(ca, sv);
    ba.rd_en = 1'b0;
    check_eq("restart_len", 32'(ca), 32'd32);
    check_eq("busy_no_valid", 32'(sv), 32'd0);
    check_eq("ready_no_valid", 32'(ba.rd_valid), 32'd0);

    // out-of-range access on the 20-word instance
    check_eq("b_ready", 32'(bb.busy), 32'd0);
    bb.wr_en   = 1'b1;
    bb.wr_addr = 5'd25;
    bb.wr_data = 3'd7;
    cyc();
    bb.wr_en   = 1'b0;
    bb.rd_en   = 1'b1;
    bb.rd_addr = 5'd25;
    cyc();
    check_eq("oor_valid", 32'(bb.rd_valid), 32'd1);
    check_eq("oor_data", 32'(bb.rd_data), 32'd1);
    bb.rd_addr = 5'd19;
    cyc();
    bb.rd_en = 1'b0;
    check_eq("last_valid", 32'(bb.rd_valid), 32'd1);
    check_eq("last_data", 32'(bb.rd_data), 32'd1);
    bb.wr_en   = 1'b1;
    bb.wr_addr = 5'd19;
    bb.wr_data = 3'd6;
    cyc();
    bb.wr_en   = 1'b0;
    bb.rd_en   = 1'b1;
    cyc();
    bb.rd_en = 1'b0;
    check_eq("b_wr19", 32'(bb.rd_data), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
